lookup_type_prio_pipe: RTL and testbench

//  Parametrised, pipelined type-lookup stage for the programmable parser. Compares a packed

---
 rtl/lookup_type_prio_pipe.sv | 183 ++++++++++++++++++
 tb/tb_lookup_type_prio_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lookup_type_prio_pipe.sv
// Pipelined masked-rule type lookup with lowest-index priority, valid/ready flow
// control, addressed rule writes, a miss-default result and saturating per-rule hit counters.
module lookup_type_prio_pipe #(
    parameter int RULE_NUM   = 8,
    parameter int TYPE_NUM   = 2,
    parameter int TYPE_WIDTH = 16,
    parameter int RESULT_W   = 32,
    parameter int TAG_W      = 8,
    parameter int CNT_W      = 32,
    parameter int OUT_REG    = 1,
    localparam int IDX_W     = $clog2(RULE_NUM) + 1,
    localparam int VEC_W     = TYPE_NUM * TYPE_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lk_valid,
    output logic                o_lk_ready,
    input  logic [VEC_W-1:0]    i_lk_type,
    input  logic [TAG_W-1:0]    i_lk_tag,
    output logic                o_rs_valid,
    input  logic                i_rs_ready,
    output logic                o_rs_hit,
    output logic [IDX_W-1:0]    o_rs_idx,
    output logic [RESULT_W-1:0] o_rs_result,
    output logic [TAG_W-1:0]    o_rs_tag,
    input  logic                i_cfg_wren,
    input  logic [IDX_W-1:0]    i_cfg_addr,
    input  logic                i_cfg_valid,
    input  logic [VEC_W-1:0]    i_cfg_data,
    input  logic [VEC_W-1:0]    i_cfg_mask,
    input  logic [RESULT_W-1:0] i_cfg_result,
    input  logic [RESULT_W-1:0] i_miss_result,
    input  logic                i_cnt_clr,
    input  logic [IDX_W-1:0]    i_cnt_rdaddr,
    output logic [CNT_W-1:0]    o_cnt_rddata
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [RULE_NUM-1:0] rule_vld;
    logic [VEC_W-1:0]    rule_data [RULE_NUM];
    logic [VEC_W-1:0]    rule_mask [RULE_NUM];
    logic [RESULT_W-1:0] rule_res  [RULE_NUM];

    logic                advance;
    logic                win_hit;
    logic [IDX_W-1:0]    win_idx;
    logic [RESULT_W-1:0] win_res;

    logic                vld_p1;
    logic                hit_p1;
    logic [IDX_W-1:0]    idx_p1;
    logic [RESULT_W-1:0] res_p1;
    logic [TAG_W-1:0]    tag_p1;

    logic [CNT_W-1:0]    cnt [RULE_NUM+1];
    logic [CNT_W-1:0]    rd_mux;
    logic [IDX_W-1:0]    cnt_sel;

    assign advance    = ~o_rs_valid | i_rs_ready;
    assign o_lk_ready = advance;

    // Rule table: enables are reset, contents are not; out-of-range addresses match no entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rule_vld <= '0;
        end else begin
            for (int i = 0; i < RULE_NUM; i++) begin
                if (i_cfg_wren && i_cfg_addr == IDX_W'(i)) rule_vld[i] <= i_cfg_valid;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < RULE_NUM; i++) begin
            if (i_cfg_wren && i_cfg_addr == IDX_W'(i)) begin
                rule_data[i] <= i_cfg_data;
                rule_mask[i] <= i_cfg_mask;
                rule_res[i]  <= i_cfg_result;
            end
        end
    end

    // Scan from the top so the lowest matching index is the last one assigned.
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        win_res = i_miss_result;
        for (int i = RULE_NUM - 1; i >= 0; i--) begin
            if (rule_vld[i] && ((rule_mask[i] & i_lk_type) == rule_data[i])) begin
                win_hit = 1'b1;
                win_idx = IDX_W'(i);
                win_res = rule_res[i];
            end
        end
    end

    // ---- stage p1: lookup result registered at accept ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
            hit_p1 <= 1'b0;
            idx_p1 <= '0;
            res_p1 <= '0;
            tag_p1 <= '0;
        end else if (advance) begin
            vld_p1 <= i_lk_valid;
            hit_p1 <= win_hit;
            idx_p1 <= win_idx;
            res_p1 <= win_res;
            tag_p1 <= i_lk_tag;
        end
    end

    // ---- stage p2: optional output register ----
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                vld_p2;
            logic                hit_p2;
            logic [IDX_W-1:0]    idx_p2;
            logic [RESULT_W-1:0] res_p2;
            logic [TAG_W-1:0]    tag_p2;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld_p2 <= 1'b0;
                    hit_p2 <= 1'b0;
                    idx_p2 <= '0;
                    res_p2 <= '0;
                    tag_p2 <= '0;
                end else if (advance) begin
                    vld_p2 <= vld_p1;
                    hit_p2 <= hit_p1;
                    idx_p2 <= idx_p1;
                    res_p2 <= res_p1;
                    tag_p2 <= tag_p1;
                end
            end

            assign o_rs_valid  = vld_p2;
            assign o_rs_hit    = hit_p2;
            assign o_rs_idx    = idx_p2;
            assign o_rs_result = res_p2;
            assign o_rs_tag    = tag_p2;
        end else begin : g_no_out_reg
            assign o_rs_valid  = vld_p1;
            assign o_rs_hit    = hit_p1;
            assign o_rs_idx    = idx_p1;
            assign o_rs_result = res_p1;
            assign o_rs_tag    = tag_p1;
        end
    endgenerate

    // Entry RULE_NUM is the miss counter.
    assign cnt_sel = o_rs_hit ? o_rs_idx : IDX_W'(RULE_NUM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i <= RULE_NUM; i++) cnt[i] <= '0;
        end else if (i_cnt_clr) begin
            for (int i = 0; i <= RULE_NUM; i++) cnt[i] <= '0;
        end else if (o_rs_valid && i_rs_ready) begin
            for (int i = 0; i <= RULE_NUM; i++) begin
                if (cnt_sel == IDX_W'(i)) cnt[i] <= sat_inc(cnt[i]);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i <= RULE_NUM; i++) begin
            if (i_cnt_rdaddr == IDX_W'(i)) rd_mux = cnt[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_cnt_rddata <= '0;
        else          o_cnt_rddata <= rd_mux;
    end

endmodule

// File: tb/tb_lookup_type_prio_pipe.sv
// Directed bench for lookup_type_prio_pipe: vector table plus hand-written flow-control,
// write-collision, counter-saturation and reset sequences.
module tb_lookup_type_prio_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lk_valid;
    logic        lk_ready, lk_ready_b;
    logic [31:0] lk_type;
    logic [7:0]  lk_tag;
    logic        rs_valid, rs_valid_b;
    logic        rs_ready;
    logic        rs_hit, rs_hit_b;
    logic [3:0]  rs_idx, rs_idx_b;
    logic [31:0] rs_result, rs_result_b;
    logic [7:0]  rs_tag, rs_tag_b;
    logic        cfg_wren;
    logic [3:0]  cfg_addr;
    logic        cfg_valid;
    logic [31:0] cfg_data, cfg_mask, cfg_result;
    logic [31:0] miss_result;
    logic        cnt_clr;
    logic [3:0]  cnt_rdaddr;
    logic [31:0] cnt_rddata;
    logic [3:0]  cnt_rddata_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lookup_type_prio_pipe u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lk_valid(lk_valid), .o_lk_ready(lk_ready), .i_lk_type(lk_type), .i_lk_tag(lk_tag),
        .o_rs_valid(rs_valid), .i_rs_ready(rs_ready), .o_rs_hit(rs_hit), .o_rs_idx(rs_idx),
        .o_rs_result(rs_result), .o_rs_tag(rs_tag),
        .i_cfg_wren(cfg_wren), .i_cfg_addr(cfg_addr), .i_cfg_valid(cfg_valid),
        .i_cfg_data(cfg_data), .i_cfg_mask(cfg_mask), .i_cfg_result(cfg_result),
        .i_miss_result(miss_result), .i_cnt_clr(cnt_clr), .i_cnt_rdaddr(cnt_rdaddr),
        .o_cnt_rddata(cnt_rddata)
    );

    // Narrow-counter build sharing all inputs, used for saturation.
    lookup_type_prio_pipe #(.CNT_W(4)) u_dut_c4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lk_valid(lk_valid), .o_lk_ready(lk_ready_b), .i_lk_type(lk_type), .i_lk_tag(lk_tag),
        .o_rs_valid(rs_valid_b), .i_rs_ready(rs_ready), .o_rs_hit(rs_hit_b), .o_rs_idx(rs_idx_b),
        .o_rs_result(rs_result_b), .o_rs_tag(rs_tag_b),
        .i_cfg_wren(cfg_wren), .i_cfg_addr(cfg_addr), .i_cfg_valid(cfg_valid),
        .i_cfg_data(cfg_data), .i_cfg_mask(cfg_mask), .i_cfg_result(cfg_result),
        .i_miss_result(miss_result), .i_cnt_clr(cnt_clr), .i_cnt_rdaddr(cnt_rdaddr),
        .o_cnt_rddata(cnt_rddata_b)
    );

    typedef struct {
        logic [31:0] t;
        logic [7:0]  tag;
        logic [31:0] miss;
        logic        hit;
        logic [3:0]  idx;
        logic [31:0] res;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic v, input logic [31:0] d,
                             input logic [31:0] m, input logic [31:0] r);
        @(negedge clk);
        cfg_wren = 1'b1; cfg_addr = a; cfg_valid = v;
        cfg_data = d; cfg_mask = m; cfg_result = r;
        @(negedge clk);
        cfg_wren = 1'b0;
    endtask

    // Single lookup with rs_ready high; returns at the negedge the result is valid.
    task automatic do_lookup(input logic [31:0] t, input logic [7:0] tg, input logic [31:0] miss,
                             output logic vld, output logic hit, output logic [3:0] idx,
                             output logic [31:0] res, output logic [7:0] otag, output int lat);
        @(negedge clk);
        lk_valid = 1'b1; lk_type = t; lk_tag = tg; miss_result = miss;
        @(negedge clk);
        lk_valid = 1'b0; miss_result = 32'h0;
        lat = 1;
        while (!rs_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        vld = rs_valid; hit = rs_hit; idx = rs_idx; res = rs_result; otag = rs_tag;
    endtask

    task automatic read_cnt(input logic [3:0] a, output logic [31:0] v, output logic [3:0] vb);
        @(negedge clk);
        cnt_rdaddr = a;
        @(negedge clk);
        v = cnt_rddata; vb = cnt_rddata_b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        vld, hit;
        logic [3:0]  idx, c4;
        logic [31:0] res, cv;
        logic [7:0]  otag, held_tag;
        int          lat, sent, rcv, stall_seen;
        logic        stalled;

        vecs[0] = '{32'h0800_1234, 8'h10, 32'h0000_0000, 1'b1, 4'd3, 32'hA5};
        vecs[1] = '{32'h1234_5678, 8'h11, 32'h0000_0000, 1'b1, 4'd1, 32'h11};
        vecs[2] = '{32'h9999_5678, 8'h12, 32'h0000_0000, 1'b1, 4'd5, 32'h55};
        vecs[3] = '{32'h0800_5678, 8'h13, 32'h0000_0000, 1'b1, 4'd3, 32'hA5};
        vecs[4] = '{32'hCAFE_BEEF, 8'h14, 32'h0000_0000, 1'b1, 4'd0, 32'hC0};
        vecs[5] = '{32'h00FF_0001, 8'h15, 32'h0000_0000, 1'b1, 4'd7, 32'h77};
        vecs[6] = '{32'h0000_0000, 8'h16, 32'h0000_DEAD, 1'b0, 4'd0, 32'hDEAD};
        vecs[7] = '{32'hCAFE_BEEE, 8'h17, 32'h0000_BEEF, 1'b0, 4'd0, 32'hBEEF};

        rst_n = 1'b0; lk_valid = 1'b0; lk_type = '0; lk_tag = '0; rs_ready = 1'b1;
        cfg_wren = 1'b0; cfg_addr = '0; cfg_valid = 1'b0; cfg_data = '0; cfg_mask = '0;
        cfg_result = '0; miss_result = '0; cnt_clr = 1'b0; cnt_rdaddr = '0;
        #23;
        check("rst_valid", {31'b0, rs_valid}, 32'd0);
        check("rst_hit", {31'b0, rs_hit}, 32'd0);
        check("rst_idx", {28'b0, rs_idx}, 32'd0);
        check("rst_result", rs_result, 32'd0);
        check("rst_tag", {24'b0, rs_tag}, 32'd0);
        check("rst_cnt", cnt_rddata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cfg_write(4'd0, 1'b1, 32'hCAFE_BEEF, 32'hFFFF_FFFF, 32'hC0);
        cfg_write(4'd1, 1'b1, 32'h1234_0000, 32'hFFFF_0000, 32'h11);
        cfg_write(4'd3, 1'b1, 32'h0800_0000, 32'hFFFF_0000, 32'hA5);
        cfg_write(4'd4, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h44);
        cfg_write(4'd5, 1'b1, 32'h0000_5678, 32'h0000_FFFF, 32'h55);
        cfg_write(4'd6, 1'b1, 32'h0000_0001, 32'h0000_0000, 32'h66);
        cfg_write(4'd7, 1'b1, 32'h00FF_0000, 32'h00FF_0000, 32'h77);
        cfg_write(4'd8, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h99);

        for (int k = 0; k < 8; k++) begin
            do_lookup(vecs[k].t, vecs[k].tag, vecs[k].miss, vld, hit, idx, res, otag, lat);
            check($sformatf("v%0d_valid", k), {31'b0, vld}, 32'd1);
            check($sformatf("v%0d_latency", k), lat, 32'd2);
            check($sformatf("v%0d_hit", k), {31'b0, hit}, {31'b0, vecs[k].hit});
            check($sformatf("v%0d_idx", k), {28'b0, idx}, {28'b0, vecs[k].idx});
            check($sformatf("v%0d_result", k), res, vecs[k].res);
            check($sformatf("v%0d_tag", k), {24'b0, otag}, {24'b0, vecs[k].tag});
        end

        read_cnt(4'd3, cv, c4);  check("cnt_rule3", cv, 32'd2);
        read_cnt(4'd7, cv, c4);  check("cnt_rule7", cv, 32'd1);
        read_cnt(4'd8, cv, c4);  check("cnt_miss", cv, 32'd2);
        read_cnt(4'd2, cv, c4);  check("cnt_rule2", cv, 32'd0);
        read_cnt(4'd9, cv, c4);  check("cnt_addr_oor", cv, 32'd0);

        cfg_write(4'd1, 1'b0, 32'h1234_0000, 32'hFFFF_0000, 32'h11);
        do_lookup(32'h1234_5678, 8'h30, 32'h0, vld, hit, idx, res, otag, lat);
        check("inval_idx", {28'b0, idx}, 32'd5);
        check("inval_result", res, 32'h55);

        // Rule write colliding with a lookup accept.
        cfg_write(4'd2, 1'b1, 32'hAAAA_0000, 32'hFFFF_0000, 32'h22);
        @(negedge clk);
        cfg_wren = 1'b1; cfg_addr = 4'd2; cfg_valid = 1'b1;
        cfg_data = 32'hAAAA_0000; cfg_mask = 32'hFFFF_0000; cfg_result = 32'h2B;
        lk_valid = 1'b1; lk_type = 32'hAAAA_0000; lk_tag = 8'h20;
        @(negedge clk);
        cfg_wren = 1'b0; lk_tag = 8'h21;
        @(negedge clk);
        lk_valid = 1'b0;
        check("wr_old_valid", {31'b0, rs_valid}, 32'd1);
        check("wr_old_idx", {28'b0, rs_idx}, 32'd2);
        check("wr_old_tag", {24'b0, rs_tag}, 32'h20);
        check("wr_old_result", rs_result, 32'h22);
        @(negedge clk);
        check("wr_new_valid", {31'b0, rs_valid}, 32'd1);
        check("wr_new_tag", {24'b0, rs_tag}, 32'h21);
        check("wr_new_result", rs_result, 32'h2B);

        // Backpressure: ready low for 5 cycles while requests keep coming.
        sent = 0; rcv = 0; stall_seen = 0; stalled = 1'b0; held_tag = '0;
        for (int c = 0; c < 60 && rcv < 10; c++) begin
            @(negedge clk);
            if (stalled) begin
                check("bp_hold_valid", {31'b0, rs_valid}, 32'd1);
                check("bp_hold_tag", {24'b0, rs_tag}, {24'b0, held_tag});
            end
            rs_ready = !(c >= 3 && c < 8);
            lk_valid = (sent < 10);
            lk_type  = 32'h0800_0000 | sent;
            lk_tag   = 8'(sent);
            #1;
            if (rs_valid && !rs_ready) begin
                check("bp_lk_ready_low", {31'b0, lk_ready}, 32'd0);
                stalled = 1'b1; held_tag = rs_tag; stall_seen++;
            end else begin
                stalled = 1'b0;
            end
            if (lk_valid && lk_ready) sent++;
            if (rs_valid && rs_ready) begin
                check("bp_order_tag", {24'b0, rs_tag}, rcv);
                check("bp_result", rs_result, 32'hA5);
                rcv++;
            end
        end
        lk_valid = 1'b0; rs_ready = 1'b1;
        check("bp_received", rcv, 32'd10);
        check("bp_sent", sent, 32'd10);
        check("bp_stall_cycles", stall_seen, 32'd5);
        @(negedge clk);
        check("bp_no_dup", {31'b0, rs_valid}, 32'd0);

        // Counter clear, single miss, saturation in the 4-bit build.
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        do_lookup(32'h0000_0000, 8'h40, 32'hDEAD, vld, hit, idx, res, otag, lat);
        check("miss_result", res, 32'hDEAD);
        read_cnt(4'd8, cv, c4);  check("cnt_miss_one", cv, 32'd1);
        for (int k = 0; k < 20; k++)
            do_lookup(32'hCAFE_BEEF, 8'(k), 32'h0, vld, hit, idx, res, otag, lat);
        read_cnt(4'd0, cv, c4);
        check("cnt32_rule0", cv, 32'd20);
        check("cnt4_sat", {28'b0, c4}, 32'hF);
        do_lookup(32'hCAFE_BEEF, 8'h41, 32'h0, vld, hit, idx, res, otag, lat);
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        read_cnt(4'd0, cv, c4);
        check("clr_wins32", cv, 32'd0);
        check("clr_wins4", {28'b0, c4}, 32'd0);

        // Asynchronous reset while a result is held.
        @(negedge clk);
        rs_ready = 1'b0; lk_valid = 1'b1; lk_type = 32'hCAFE_BEEF; lk_tag = 8'h55;
        @(negedge clk); lk_valid = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", {31'b0, rs_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, rs_valid}, 32'd0);
        check("mid_rst_tag", {24'b0, rs_tag}, 32'd0);
        @(negedge clk); rst_n = 1'b1; rs_ready = 1'b1;
        @(negedge clk);
        check("mid_post_valid", {31'b0, rs_valid}, 32'd0);
        do_lookup(32'hCAFE_BEEF, 8'h56, 32'h1357, vld, hit, idx, res, otag, lat);
        check("mid_rules_cleared_hit", {31'b0, hit}, 32'd0);
        check("mid_rules_cleared_res", res, 32'h1357);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
